// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU op classes, datapath select codes and the 4-bit ALU control values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU control decoder: maps the FSM's ALU op class plus the R-type funct
// field onto the 4-bit ALU control code.
module aludec
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUCTL_ADD;
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            default: begin
                // Unrecognised funct codes fall back to add.
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_mainfsm.sv
// Main control FSM: state register, next-state logic and Moore output decode,
// with memready gating the fetch strobes and the memory wait states.
module mc_mainfsm
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcwrite,
    output logic       branch,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    state_t state_reg;
    state_t state_next;
    state_t out_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // While reset is held the outputs already look like FETCH, so the
    // datapath sees a clean fetch setup the moment reset drops.
    assign out_state = reset ? FETCH : state_reg;
    assign state     = out_state;

    always_comb begin
        state_next = state_reg;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;

        case (state_reg)
            FETCH:   if (memready) state_next = DECODE;
            DECODE: begin
                if (is_mem_op(op))       state_next = MEMADR;
                else if (op == OP_RTYPE) state_next = EXECUTE;
                else if (op == OP_BEQ)   state_next = BRANCH;
                else if (op == OP_ADDI)  state_next = ADDIEX;
                else if (op == OP_J)     state_next = JUMP;
                else                     state_next = FETCH;
            end
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (memready) state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   if (memready) state_next = FETCH;
            EXECUTE: state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            BRANCH:  state_next = FETCH;
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
            JUMP:    state_next = FETCH;
            default: state_next = FETCH;
        endcase

        case (out_state)
            FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = memready;
                pcwrite = memready;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                illegal = !(is_mem_op(op) || op == OP_RTYPE || op == OP_BEQ ||
                            op == OP_ADDI || op == OP_J);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REG;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller top: main FSM plus ALU decoder, and the PC enable
// that combines unconditional PC writes with taken branches.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic [3:0] state
);

    logic [1:0] aluop;

    mc_mainfsm u_mainfsm (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .iord     (iord),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .illegal  (illegal),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .state    (state)
    );

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each stimulus cycle queues its
// hand-derived expected outputs, and a negedge monitor checks them in order.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic       pcwrite, branch, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .irwrite(irwrite),
        .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .pcwrite(pcwrite),
        .branch(branch), .pcen(pcen), .illegal(illegal), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] ctl;   // iord irwrite memwrite memtoreg regdst regwrite alusrca
        logic [1:0] srcb;
        logic [1:0] psrc;
        logic [3:0] flg;   // pcwrite branch pcen illegal
        logic [3:0] aluc;
    } obs_t;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_AND = 4'b0000;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    obs_t  exp_q[$];
    string lbl_q[$];
    int    total = 0;
    int    bad   = 0;

    // Expected outputs for one cycle, straight from the state table.
    function automatic obs_t ex(state_t s, logic mr, logic z, logic ill, logic [3:0] ax);
        obs_t e;
        e = '0;
        e.st   = s;
        e.aluc = A_ADD;
        case (s)
            FETCH:   begin e.srcb = 2'b01; e.ctl = {1'b0, mr, 5'b0}; e.flg = {mr, 1'b0, mr, 1'b0}; end
            DECODE:  begin e.srcb = 2'b11; e.flg = {3'b000, ill}; end
            MEMADR:  begin e.srcb = 2'b10; e.ctl = 7'b0000001; end
            MEMRD:   e.ctl = 7'b1000000;
            MEMWB:   e.ctl = 7'b0001010;
            MEMWR:   e.ctl = 7'b1010000;
            EXECUTE: begin e.ctl = 7'b0000001; e.aluc = ax; end
            ALUWB:   e.ctl = 7'b0000110;
            BRANCH:  begin e.ctl = 7'b0000001; e.psrc = 2'b01; e.flg = {1'b0, 1'b1, z, 1'b0}; e.aluc = A_SUB; end
            ADDIEX:  begin e.srcb = 2'b10; e.ctl = 7'b0000001; end
            ADDIWB:  e.ctl = 7'b0000010;
            JUMP:    begin e.psrc = 2'b10; e.flg = 4'b1010; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input string n, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic mr, input obs_t e);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; zero = z; memready = mr;
        exp_q.push_back(e);
        lbl_q.push_back(n);
    endtask

    task automatic c(input string n, input logic [5:0] o, input state_t s,
                     input logic mr = 1'b1, input logic z = 1'b0,
                     input logic [5:0] f = 6'b100000, input logic ill = 1'b0,
                     input logic [3:0] ax = A_ADD);
        cyc(n, 1'b0, o, f, z, mr, ex(s, mr, z, ill, ax));
    endtask

    task automatic rst_cyc(input string n, input logic mr);
        cyc(n, 1'b1, LW, 6'b0, 1'b1, mr, ex(FETCH, 1'b0, 1'b0, 1'b0, A_ADD));
    endtask

    always @(negedge clk) begin : monitor
        obs_t  e, a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = lbl_q.pop_front();
            a = {state, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
                 alusrcb, pcsrc, pcwrite, branch, pcen, illegal, alucontrol};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got st=%0d ctl=%b srcb=%b pcsrc=%b flg=%b aluc=%b, want st=%0d ctl=%b srcb=%b pcsrc=%b flg=%b aluc=%b",
                         n, a.st, a.ctl, a.srcb, a.psrc, a.flg, a.aluc,
                         e.st, e.ctl, e.srcb, e.psrc, e.flg, e.aluc);
            end else begin
                $display("ok   %s: st=%0d ctl=%b flg=%b aluc=%b", n, a.st, a.ctl, a.flg, a.aluc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; memready = 1'b1;

        rst_cyc("reset0", 1'b1);
        rst_cyc("reset1", 1'b1);

        // lw, no waits: 5 cycles
        c("lw_fetch", LW, FETCH);
        c("lw_decode", LW, DECODE);
        c("lw_memadr", LW, MEMADR);
        c("lw_memrd", LW, MEMRD);
        c("lw_memwb", LW, MEMWB);

        // sw with three memory wait cycles: 7 cycles
        c("sw_fetch", SW, FETCH);
        c("sw_decode", SW, DECODE);
        c("sw_memadr", SW, MEMADR);
        c("sw_wait0", SW, MEMWR, 1'b0);
        c("sw_wait1", SW, MEMWR, 1'b0);
        c("sw_wait2", SW, MEMWR, 1'b0);
        c("sw_memwr", SW, MEMWR, 1'b1);

        // beq taken and not taken
        c("beq1_fetch", BEQ, FETCH);
        c("beq1_decode", BEQ, DECODE);
        c("beq1_branch", BEQ, BRANCH, 1'b1, 1'b1);
        c("beq0_fetch", BEQ, FETCH);
        c("beq0_decode", BEQ, DECODE);
        c("beq0_branch", BEQ, BRANCH, 1'b1, 1'b0);

        // R-type sub, and, unknown funct
        c("rsub_fetch", RT, FETCH, 1'b1, 1'b0, 6'b100010);
        c("rsub_decode", RT, DECODE, 1'b1, 1'b0, 6'b100010);
        c("rsub_exec", RT, EXECUTE, 1'b1, 1'b0, 6'b100010, 1'b0, A_SUB);
        c("rsub_aluwb", RT, ALUWB, 1'b1, 1'b0, 6'b100010);
        c("rand_fetch", RT, FETCH, 1'b1, 1'b0, 6'b100100);
        c("rand_decode", RT, DECODE, 1'b1, 1'b0, 6'b100100);
        c("rand_exec", RT, EXECUTE, 1'b1, 1'b0, 6'b100100, 1'b0, A_AND);
        c("rand_aluwb", RT, ALUWB, 1'b1, 1'b0, 6'b100100);
        c("runk_fetch", RT, FETCH, 1'b1, 1'b0, 6'b111011);
        c("runk_decode", RT, DECODE, 1'b1, 1'b0, 6'b111011);
        c("runk_exec", RT, EXECUTE, 1'b1, 1'b0, 6'b111011, 1'b0, A_ADD);
        c("runk_aluwb", RT, ALUWB, 1'b1, 1'b0, 6'b111011);

        // addi and j
        c("addi_fetch", ADDI, FETCH);
        c("addi_decode", ADDI, DECODE);
        c("addi_ex", ADDI, ADDIEX);
        c("addi_wb", ADDI, ADDIWB);
        c("j_fetch", JMP, FETCH);
        c("j_decode", JMP, DECODE);
        c("j_jump", JMP, JUMP);

        // illegal opcode returns to FETCH after one DECODE cycle
        c("ill_fetch", BAD, FETCH);
        c("ill_decode", BAD, DECODE, 1'b1, 1'b0, 6'b100000, 1'b1);

        // lw with a fetch wait and a read wait: 7 cycles
        c("lww_fetch0", LW, FETCH, 1'b0);
        c("lww_fetch1", LW, FETCH, 1'b1);
        c("lww_decode", LW, DECODE);
        c("lww_memadr", LW, MEMADR);
        c("lww_memrd0", LW, MEMRD, 1'b0);
        c("lww_memrd1", LW, MEMRD, 1'b1);
        c("lww_memwb", LW, MEMWB);

        // reset while waiting in MEMRD
        c("rrd_fetch", LW, FETCH);
        c("rrd_decode", LW, DECODE);
        c("rrd_memadr", LW, MEMADR);
        c("rrd_memrd0", LW, MEMRD, 1'b0);
        c("rrd_memrd1", LW, MEMRD, 1'b0);
        rst_cyc("rrd_reset", 1'b0);
        c("rrd_after", LW, FETCH, 1'b0);

        // reset while waiting in MEMWR, memready high during reset
        c("rwr_fetch", SW, FETCH);
        c("rwr_decode", SW, DECODE);
        c("rwr_memadr", SW, MEMADR);
        c("rwr_memwr0", SW, MEMWR, 1'b0);
        rst_cyc("rwr_reset", 1'b1);
        c("rwr_after", SW, FETCH, 1'b1);
        c("rwr_decode2", SW, DECODE);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as listed here.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 memready  input  1  memory access completes this cycle.
REQ-008 The block SHALL have these single-bit outputs: iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, pcwrite, branch, pcen, illegal.
REQ-009 alusrcb  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-010 pcsrc  output  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 alucontrol  output  4  ALU operation, using the team's existing 4-bit encoding.
REQ-012 state  output  4  current state, for debug only.

Function
REQ-013 The block SHALL be a Moore FSM: outputs depend only on state, except that memready gates outputs as stated below and pcen.
REQ-014 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-015 Any output not listed for a state SHALL be 0, and any bus output not listed SHALL be 00.
REQ-016 FETCH: alusrcb=01 and aluop=00; irwrite and pcwrite SHALL equal memready; the FSM moves to DECODE when memready=1, otherwise it stays in FETCH.
REQ-017 DECODE: alusrcb=11 and aluop=00; next state is selected by op: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
REQ-018 Any other opcode in DECODE SHALL assert illegal for one cycle and return to FETCH.
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state is MEMRD for op=100011, otherwise MEMWR.
REQ-020 MEMRD: iord=1; the FSM moves to MEMWB when memready=1, otherwise it stays in MEMRD.
REQ-021 MEMWB: memtoreg=1 and regwrite=1; next state is FETCH.
REQ-022 MEMWR: iord=1 and memwrite=1; memwrite SHALL be held high until memready=1, at which point the FSM moves to FETCH.
REQ-023 EXECUTE: alusrca=1, alusrcb=00, aluop=10; next state is ALUWB.
REQ-024 ALUWB: regdst=1 and regwrite=1; next state is FETCH.
REQ-025 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1; next state is FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state is ADDIWB.
REQ-027 ADDIWB: regwrite=1 and regdst=0; next state is FETCH.
REQ-028 JUMP: pcsrc=10 and pcwrite=1; next state is FETCH.
REQ-029 pcen SHALL equal pcwrite | (branch & zero).
REQ-030 alucontrol SHALL be derived from aluop:
- 00 -> add;
- 01 -> subtract;
- 10 -> decoded from funct;
- any funct that is not recognised -> the add encoding.
REQ-031 Instruction latency SHALL be counted in cycles with memready tied to 1:
- lw: 5 cycles;
- sw: 4 cycles;
- R-type: 4 cycles;
- addi: 4 cycles;
- beq: 3 cycles;
- j: 3 cycles.
REQ-032 Each cycle with memready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to the instruction latency.

Reset
REQ-033 On a rising clk edge with reset=1, the state SHALL become FETCH, regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-034 While reset=1, these outputs SHALL be forced to 0: irwrite, pcwrite, pcen, memwrite, regwrite, illegal.
REQ-035 While reset=1, the other outputs SHALL take their FETCH values.
REQ-036 No output register SHALL exist outside the state register.

Structure
REQ-037 A shared package SHALL hold:
- the state enum (4 bits);
- the opcode constants;
- the aluop constants (00 add, 01 sub, 10 funct);
- the alusrcb and pcsrc select encodings.
REQ-038 One sub-module, mc_mainfsm, SHALL contain the state register, next-state logic and output decode.
REQ-039 ALU decode SHALL reuse the team's existing aludec unchanged; the top level SHALL contain only instances and the pcen logic.

Verification
REQ-040 lw with memready=1 throughout: reset, then op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-041 sw with memready=0 for 3 cycles in MEMWR: op=101011 -> memwrite held high for 4 cycles, then FETCH; total 7 cycles.
REQ-042 beq: op=000100 with zero=1 -> pcen=1 in BRANCH; with zero=0 -> pcen=0; both cases return to FETCH in cycle 4.
REQ-043 R-type: op=000000, funct=100010 -> alucontrol equals the subtract encoding in EXECUTE; regdst=1 and regwrite=1 in ALUWB.
REQ-044 Illegal opcode: op=111111 -> illegal=1 for one cycle in DECODE, then FETCH, with no regwrite or memwrite asserted.
REQ-045 Reset mid-operation: reset=1 while in MEMRD with memready=0 -> state is FETCH on the next edge, and memwrite, regwrite, pcen stay 0 throughout.
